// File: rtl/mem_lsu.sv
// mem_lsu: RV32I memory-stage load/store unit (optional MISALIGN_TRAP_EN adds misaligned-access trap)
module mem_lsu #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rd_en_M,
    input  logic [2:0]        wr_en_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [31:0]       wdata_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic [31:0]       load_data_M,
    output logic              mem_stall,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              timeout_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          st, ld, access, trap, limit;
    logic [1:0]    sz, off, off_q;
    logic [3:0]    be_c;
    logic [31:0]   wd_c, sh, fmt;
    logic [2:0]    lty;

    // Decode the M-stage instruction: size (0 byte, 1 half, 2 word), aligned lane, enables, lane data
    always_comb begin
        st     = wr_en_M inside {3'b001, 3'b010, 3'b011};
        ld     = rd_en_M inside {[3'b001:3'b101]};
        access = st | ld;
        sz     = st ? wr_en_M[1:0] - 2'd1 :
                 (rd_en_M == 3'b011) ? 2'd2 :
                 (rd_en_M == 3'b010 || rd_en_M == 3'b101) ? 2'd1 : 2'd0;
        off    = (sz == 2'd2) ? 2'b00 : (sz == 2'd1) ? {addr_M[1], 1'b0} : addr_M[1:0];
        be_c   = (sz == 2'd2) ? 4'b1111 : (sz == 2'd1) ? 4'b0011 << off : 4'b0001 << off;
        wd_c   = (sz == 2'd2) ? wdata_M : (sz == 2'd1) ? {2{wdata_M[15:0]}} : {4{wdata_M[7:0]}};
`ifdef MISALIGN_TRAP_EN
        trap   = access & (((sz == 2'd1) & addr_M[0]) | ((sz == 2'd2) & (addr_M[1:0] != 2'b00)));
`else
        trap   = 1'b0;
`endif
        limit  = cnt == CW'(MAX_WAIT - 1);
    end

    // Extract the addressed lane from the read word and extend it per load type
    always_comb begin
        sh  = dmem_rdata >> {off_q, 3'b000};
        fmt = (lty == 3'b001) ? {{24{sh[7]}}, sh[7:0]} :
              (lty == 3'b010) ? {{16{sh[15]}}, sh[15:0]} :
              (lty == 3'b011) ? sh :
              (lty == 3'b100) ? {24'd0, sh[7:0]} :
              (lty == 3'b101) ? {16'd0, sh[15:0]} : 32'd0;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and stall; stall drops with reset so a killed access frees the pipeline at once
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = access & rst;
                state_nxt = access ? (trap ? DONE : REQ) : IDLE;
            end
            REQ: begin
                mem_stall = 1'b1;
                state_nxt = (dmem_ack || limit) ? DONE : REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dmem_req = (state == REQ);

    // Request registers, wait counter, load capture and one-cycle status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_we     <= 1'b0;
            dmem_be     <= 4'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= 32'd0;
            load_data_M <= 32'd0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            lty         <= 3'b000;
            off_q       <= 2'b00;
`ifdef MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            timeout_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
            if (state == IDLE && access && !trap) begin
                dmem_addr  <= {addr_M[ADDR_W-1:2], 2'b00};
                dmem_be    <= be_c;
                dmem_we    <= st;
                dmem_wdata <= wd_c;
                lty        <= st ? 3'b000 : rd_en_M;
                off_q      <= off;
                cnt        <= '0;
            end
            if (state == IDLE && trap) begin
                load_data_M <= 32'd0;
`ifdef MISALIGN_TRAP_EN
                misalign    <= 1'b1;
`endif
            end
            if (state == REQ) begin
                cnt <= cnt + 1'b1;
                if (dmem_ack) begin
                    load_data_M <= fmt;
                end else if (limit) begin
                    load_data_M <= 32'd0;
                    timeout_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  rd_en_M = 3'b000;
    logic [2:0]  wr_en_M = 3'b000;
    logic [31:0] addr_M = 32'd0;
    logic [31:0] wdata_M = 32'd0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0, load_data_M;
    logic        mem_stall, timeout_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int failures = 0;
    int n_stall, n_req;
    logic        stable, done_ok, c_we;
    logic [3:0]  c_be;
    logic [31:0] c_addr, c_wdata;

    mem_lsu dut (
        .clk(clk), .rst(rst), .rd_en_M(rd_en_M), .wr_en_M(wr_en_M),
        .addr_M(addr_M), .wdata_M(wdata_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .load_data_M(load_data_M),
        .mem_stall(mem_stall),
`ifdef MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one instruction from IDLE, acks on REQ cycle dly+1, returns while in DONE
    task automatic run(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdat, input int dly);
        rd_en_M = rd; wr_en_M = wr; addr_M = a; wdata_M = wd;
        #1;
        n_stall = 0; n_req = 0; stable = 1'b1; done_ok = 1'b0;
        c_addr = 32'd0; c_be = 4'd0; c_we = 1'b0; c_wdata = 32'd0;
        for (int i = 0; i < 40; i++) begin
            dmem_ack = 1'b0;
            if (!mem_stall) begin
                done_ok = 1'b1;
                break;
            end
            n_stall++;
            if (dmem_req) begin
                if (n_req == 0) begin
                    c_addr = dmem_addr; c_be = dmem_be; c_we = dmem_we; c_wdata = dmem_wdata;
                end else if (dmem_addr !== c_addr || dmem_be !== c_be) stable = 1'b0;
                n_req++;
                dmem_ack = (n_req == dly + 1);
                dmem_rdata = rdat;
            end
            @(negedge clk); #1;
        end
        rd_en_M = 3'b000; wr_en_M = 3'b000; dmem_ack = 1'b0;
        chk("done_reached", {31'd0, done_ok}, 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_load", load_data_M, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk); rst = 1'b1;

        @(negedge clk);
        rd_en_M = 3'b110; #1;
        chk("nonmem_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk); #1;
        chk("nonmem_req", {31'd0, dmem_req}, 32'd0);
        rd_en_M = 3'b000;

        @(negedge clk);
        run(3'b000, 3'b001, 32'h103, 32'h0000_00A5, 32'd0, 0);
        chk("sb_be", {28'd0, c_be}, 32'h8);
        chk("sb_wdata", c_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", c_addr, 32'h100);
        chk("sb_we", {31'd0, c_we}, 32'd1);
        chk("sb_stalls", n_stall, 2);
        chk("sb_done_req", {31'd0, dmem_req}, 32'd0);

        @(negedge clk);
        run(3'b001, 3'b000, 32'h102, 32'd0, 32'h0080_0000, 0);
        chk("lb_be", {28'd0, c_be}, 32'h4);
        chk("lb_we", {31'd0, c_we}, 32'd0);
        chk("lb_data", load_data_M, 32'hFFFF_FF80);
        @(negedge clk);
        run(3'b100, 3'b000, 32'h102, 32'd0, 32'h0080_0000, 0);
        chk("lbu_data", load_data_M, 32'h0000_0080);
        @(negedge clk);
        run(3'b101, 3'b000, 32'h102, 32'd0, 32'h8001_0000, 0);
        chk("lhu_be", {28'd0, c_be}, 32'hC);
        chk("lhu_data", load_data_M, 32'h0000_8001);
        @(negedge clk);
        run(3'b010, 3'b000, 32'h102, 32'd0, 32'h8001_0000, 0);
        chk("lh_data", load_data_M, 32'hFFFF_8001);
        @(negedge clk);
        run(3'b000, 3'b010, 32'h102, 32'h1234_BEEF, 32'd0, 0);
        chk("sh_be", {28'd0, c_be}, 32'hC);
        chk("sh_wdata", c_wdata, 32'hBEEF_BEEF);

        @(negedge clk);
        run(3'b011, 3'b000, 32'h200, 32'd0, 32'hDEAD_BEEF, 5);
        chk("lw_reqs", n_req, 6);
        chk("lw_stalls", n_stall, 7);
        chk("lw_stable", {31'd0, stable}, 32'd1);
        chk("lw_be", {28'd0, c_be}, 32'hF);
        chk("lw_data", load_data_M, 32'hDEAD_BEEF);

        @(negedge clk);
        run(3'b011, 3'b000, 32'h204, 32'd0, 32'h5555_AAAA, 99);
        chk("to_reqs", n_req, 15);
        chk("to_stalls", n_stall, 16);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_load", load_data_M, 32'd0);
        @(negedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        chk("to_err_pulse", {31'd0, timeout_err}, 32'd0);
        @(negedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
        chk("late_ack_load", load_data_M, 32'd0);

        @(negedge clk);
        run(3'b011, 3'b000, 32'h208, 32'd0, 32'h0BAD_F00D, 14);
        chk("edge_reqs", n_req, 15);
        chk("edge_err", {31'd0, timeout_err}, 32'd0);
        chk("edge_data", load_data_M, 32'h0BAD_F00D);

        @(negedge clk);
        rd_en_M = 3'b011; addr_M = 32'h300; #1;
        chk("rr_stall_idle", {31'd0, mem_stall}, 32'd1);
        @(negedge clk); #1;
        chk("rr_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b0; #1;
        chk("rr_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("rr_stall_drop", {31'd0, mem_stall}, 32'd0);
        rd_en_M = 3'b000;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        run(3'b011, 3'b000, 32'h304, 32'd0, 32'h1234_5678, 0);
        chk("rr_lw_data", load_data_M, 32'h1234_5678);
        chk("rr_lw_stalls", n_stall, 2);

        @(negedge clk);
        run(3'b011, 3'b001, 32'h101, 32'h0000_003C, 32'hFFFF_FFFF, 0);
        chk("both_we", {31'd0, c_we}, 32'd1);
        chk("both_be", {28'd0, c_be}, 32'h2);
        chk("both_wdata", c_wdata, 32'h3C3C_3C3C);
        chk("both_load", load_data_M, 32'd0);

        @(negedge clk);
        run(3'b000, 3'b011, 32'h102, 32'hCAFE_0001, 32'd0, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_reqs", n_req, 0);
        chk("mis_stalls", n_stall, 1);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_load", load_data_M, 32'd0);
`else
        chk("sw_addr", c_addr, 32'h100);
        chk("sw_be", {28'd0, c_be}, 32'hF);
        chk("sw_wdata", c_wdata, 32'hCAFE_0001);
        chk("sw_reqs", n_req, 1);
`endif
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
